// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : bus_arbiter
//  Description : Two-master / two-slave shared-bus arbiter. Parks the grant on
//                master 0, muxes the owner's request onto the slave bus,
//                decodes the slave window and returns one-cycle-late read data.
//  Revision    : 1.0  initial release
// ============================================================================
module bus_arbiter #(
    parameter logic [2:0] S0_BASE = 3'b000,
    parameter logic [2:0] S1_BASE = 3'b001
) (
    input  logic        clk,
    input  logic        reset,
    // master 0 (DMA master)
    input  logic        M0_req,
    input  logic        M0_wr,
    input  logic [7:0]  M0_address,
    input  logic [31:0] M0_dout,
    output logic        M0_grant,
    output logic [31:0] M0_din,
    // master 1 (host)
    input  logic        M1_req,
    input  logic        M1_wr,
    input  logic [7:0]  M1_address,
    input  logic [31:0] M1_dout,
    output logic        M1_grant,
    output logic [31:0] M1_din,
    // slave side
    output logic        S0_sel,
    output logic        S1_sel,
    output logic        S_wr,
    output logic [7:0]  S_address,
    output logic [31:0] S_din,
    input  logic [31:0] S0_dout,
    input  logic [31:0] S1_dout,
    output logic        bus_err
);

    localparam logic [0:0] ST_M0_GRANT = 1'b0;
    localparam logic [0:0] ST_M1_GRANT = 1'b1;

    localparam logic [1:0] RD_NONE = 2'd0;
    localparam logic [1:0] RD_S0   = 2'd1;
    localparam logic [1:0] RD_S1   = 2'd2;

    logic [0:0]  r_state;
    logic [0:0]  w_state_nxt;
    logic [1:0]  r_rd_sel;
    logic [1:0]  w_rd_sel_nxt;
    logic        r_bus_err;

    logic        w_req;
    logic        w_wr;
    logic [7:0]  w_addr;
    logic [31:0] w_dout;
    logic [2:0]  w_win;
    logic        w_hit0;
    logic        w_hit1;
    logic [31:0] w_rdata;

    // Next-state logic: owner keeps the bus while it requests, idle parks on M0
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_M0_GRANT: begin
                if (!M0_req && M1_req)
                    w_state_nxt = ST_M1_GRANT;
            end
            ST_M1_GRANT: begin
                if (!M1_req)
                    w_state_nxt = ST_M0_GRANT;
            end
            default: w_state_nxt = ST_M0_GRANT;
        endcase
    end

    // Arbiter state register
    always_ff @(posedge clk) begin
        if (reset)
            r_state <= ST_M0_GRANT;
        else
            r_state <= w_state_nxt;
    end

    // Grants come straight from the state, never from the request inputs
    assign M0_grant = (r_state == ST_M0_GRANT);
    assign M1_grant = (r_state == ST_M1_GRANT);

    // Select the owner's request signals
    always_comb begin
        if (r_state == ST_M1_GRANT) begin
            w_req  = M1_req;
            w_wr   = M1_wr;
            w_addr = M1_address;
            w_dout = M1_dout;
        end else begin
            w_req  = M0_req;
            w_wr   = M0_wr;
            w_addr = M0_address;
            w_dout = M0_dout;
        end
    end

    // Slave bus is driven to zero whenever the owner is not requesting
    assign S_address = w_req ? w_addr : 8'h00;
    assign S_din     = w_req ? w_dout : 32'h0;
    assign S_wr      = w_req & w_wr;

    // Window decode; slave 1 yields to slave 0 so only one select can be high
    assign w_win  = S_address[7:5];
    assign w_hit0 = w_req && (w_win == S0_BASE);
    assign w_hit1 = w_req && (w_win == S1_BASE) && !w_hit0;
    assign S0_sel = w_hit0;
    assign S1_sel = w_hit1;

    // Remember which slave a read targeted so its data can be steered next cycle
    always_comb begin
        w_rd_sel_nxt = RD_NONE;
        if (w_req && !w_wr) begin
            if (w_hit0)
                w_rd_sel_nxt = RD_S0;
            else if (w_hit1)
                w_rd_sel_nxt = RD_S1;
        end
    end

    // Read-return select and bus-error pulse registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_sel  <= RD_NONE;
            r_bus_err <= 1'b0;
        end else begin
            r_rd_sel  <= w_rd_sel_nxt;
            r_bus_err <= w_req && !w_hit0 && !w_hit1;
        end
    end

    assign bus_err = r_bus_err;

    // Read data is broadcast to both masters; only the requester consumes it
    always_comb begin
        case (r_rd_sel)
            RD_S0:   w_rdata = S0_dout;
            RD_S1:   w_rdata = S1_dout;
            default: w_rdata = 32'h0;
        endcase
    end

    assign M0_din = w_rdata;
    assign M1_din = w_rdata;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bus_arbiter
//  Description : Self-checking bench for bus_arbiter. A reference model
//                predicts grant and slave-bus values each cycle and pushes the
//                expected read data / bus error for the following cycle into a
//                scoreboard queue, which is popped after the next clock edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bus_arbiter;

    localparam logic [31:0] C_S0_DATA = 32'hA5A5_0001;
    localparam logic [31:0] C_S1_DATA = 32'h5A5A_0002;

    logic        clk;
    logic        reset;
    logic        M0_req, M0_wr, M1_req, M1_wr;
    logic [7:0]  M0_address, M1_address;
    logic [31:0] M0_dout, M1_dout;
    logic        M0_grant, M1_grant;
    logic [31:0] M0_din, M1_din;
    logic        S0_sel, S1_sel, S_wr;
    logic [7:0]  S_address;
    logic [31:0] S_din;
    logic [31:0] S0_dout, S1_dout;
    logic        bus_err;

    bus_arbiter #(
        .S0_BASE (3'b000),
        .S1_BASE (3'b001)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .M0_req     (M0_req),
        .M0_wr      (M0_wr),
        .M0_address (M0_address),
        .M0_dout    (M0_dout),
        .M0_grant   (M0_grant),
        .M0_din     (M0_din),
        .M1_req     (M1_req),
        .M1_wr      (M1_wr),
        .M1_address (M1_address),
        .M1_dout    (M1_dout),
        .M1_grant   (M1_grant),
        .M1_din     (M1_din),
        .S0_sel     (S0_sel),
        .S1_sel     (S1_sel),
        .S_wr       (S_wr),
        .S_address  (S_address),
        .S_din      (S_din),
        .S0_dout    (S0_dout),
        .S1_dout    (S1_dout),
        .bus_err    (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] din;
        logic        err;
    } exp_t;

    exp_t exp_q[$];

    int   n_chk  = 0;
    int   n_fail = 0;
    logic m_state = 1'b0;   // 0 = master 0 owns the bus, 1 = master 1

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One bus cycle: check combinational outputs against the model, push the
    // registered-output prediction, advance through the clock edge, then pop
    // and compare the registered outputs.
    task automatic tick();
        logic        req, wr, s0, s1;
        logic [7:0]  addr;
        logic [31:0] dat;
        exp_t        e;
        exp_t        got;

        #3;
        req  = m_state ? M1_req : M0_req;
        wr   = m_state ? M1_wr : M0_wr;
        addr = req ? (m_state ? M1_address : M0_address) : 8'h00;
        dat  = req ? (m_state ? M1_dout : M0_dout) : 32'h0;
        s0   = req && (addr[7:5] == 3'b000);
        s1   = req && (addr[7:5] == 3'b001);

        chk("M0_grant",  {31'b0, M0_grant}, {31'b0, !m_state});
        chk("M1_grant",  {31'b0, M1_grant}, {31'b0, m_state});
        chk("S_address", {24'b0, S_address}, {24'b0, addr});
        chk("S_din",     S_din, dat);
        chk("S_wr",      {31'b0, S_wr}, {31'b0, req & wr});
        chk("S0_sel",    {31'b0, S0_sel}, {31'b0, s0});
        chk("S1_sel",    {31'b0, S1_sel}, {31'b0, s1});

        if (reset) begin
            e.din = 32'h0;
            e.err = 1'b0;
        end else begin
            e.din = (req && !wr) ? (s0 ? C_S0_DATA : (s1 ? C_S1_DATA : 32'h0)) : 32'h0;
            e.err = req && !s0 && !s1;
        end
        exp_q.push_back(e);

        @(posedge clk);
        if (reset)
            m_state = 1'b0;
        else if (!m_state)
            m_state = (!M0_req && M1_req);
        else
            m_state = M1_req;
        #1;

        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            got = exp_q.pop_front();
            chk("M0_din",  M0_din, got.din);
            chk("M1_din",  M1_din, got.din);
            chk("bus_err", {31'b0, bus_err}, {31'b0, got.err});
        end
    endtask

    task automatic drv_m0(input logic req, input logic wr, input logic [7:0] a, input logic [31:0] d);
        M0_req = req; M0_wr = wr; M0_address = a; M0_dout = d;
    endtask

    task automatic drv_m1(input logic req, input logic wr, input logic [7:0] a, input logic [31:0] d);
        M1_req = req; M1_wr = wr; M1_address = a; M1_dout = d;
    endtask

    initial begin
        reset   = 1'b1;
        S0_dout = C_S0_DATA;
        S1_dout = C_S1_DATA;
        drv_m0(1'b0, 1'b0, 8'h00, 32'h0);
        drv_m1(1'b0, 1'b0, 8'h00, 32'h0);

        // bring the DUT into a known state before any checking
        @(posedge clk);
        #1;
        m_state = 1'b0;
        tick();                                   // reset state checks
        reset = 1'b0;

        // M0 read from slave 0 with zero grant latency
        drv_m0(1'b1, 1'b0, 8'h04, 32'h0);
        tick();
        drv_m0(1'b0, 1'b0, 8'h00, 32'h0);
        tick();

        // M1 write to slave 1: granted one cycle after request
        drv_m1(1'b1, 1'b1, 8'h21, 32'h0000_00FF);
        tick();
        tick();
        drv_m1(1'b0, 1'b0, 8'h00, 32'h0);
        tick();

        // M1 owns the bus, M0 requests and waits for release
        drv_m1(1'b1, 1'b0, 8'h30, 32'h0);
        tick();
        tick();
        drv_m0(1'b1, 1'b0, 8'h08, 32'h0);
        tick();
        tick();
        drv_m1(1'b0, 1'b0, 8'h00, 32'h0);
        tick();
        tick();
        drv_m0(1'b0, 1'b0, 8'h00, 32'h0);
        tick();

        // simultaneous requests out of reset: M0 wins
        reset = 1'b1;
        drv_m0(1'b1, 1'b1, 8'h10, 32'h1234_5678);
        drv_m1(1'b1, 1'b0, 8'h24, 32'h0);
        tick();
        reset = 1'b0;
        tick();
        tick();
        drv_m0(1'b0, 1'b0, 8'h00, 32'h0);
        tick();
        tick();
        drv_m1(1'b0, 1'b0, 8'h00, 32'h0);
        tick();

        // unmapped read: no select, one-cycle bus_err, zero data
        drv_m0(1'b1, 1'b0, 8'h80, 32'h0);
        tick();
        drv_m0(1'b0, 1'b0, 8'h00, 32'h0);
        tick();
        tick();

        // back-to-back pipelined reads and writes, including window edges
        drv_m0(1'b1, 1'b0, 8'h00, 32'h0); tick();
        drv_m0(1'b1, 1'b0, 8'h20, 32'h0); tick();
        drv_m0(1'b1, 1'b0, 8'h1F, 32'h0); tick();
        drv_m0(1'b1, 1'b0, 8'h3F, 32'h0); tick();
        drv_m0(1'b1, 1'b1, 8'h40, 32'hDEAD_BEEF); tick();
        drv_m0(1'b1, 1'b0, 8'hFF, 32'h0); tick();
        drv_m0(1'b0, 1'b0, 8'h00, 32'h0); tick();

        // reset while M1 is mid-write
        drv_m1(1'b1, 1'b1, 8'h22, 32'hCAFE_0001);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        drv_m1(1'b0, 1'b0, 8'h00, 32'h0);
        tick();

        // random traffic
        for (int i = 0; i < 60; i++) begin
            drv_m0(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   8'($urandom_range(0, 255)), $urandom);
            drv_m1(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   8'($urandom_range(0, 95)), $urandom);
            tick();
        end
        drv_m0(1'b0, 1'b0, 8'h00, 32'h0);
        drv_m1(1'b0, 1'b0, 8'h00, 32'h0);
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
